ch_msg_ram_loader: RTL
======================

# ch_msg_ram_loader

Write-side front end for the channel message RAM. Accepts channel LLRs streamed as CH_IN_NUM-wide beats over a valid/ready handshake and packs BEAT_NUM beats into one codeword page. It then issues a single-cycle write (we_o, write_addr_o, din_o) into the channel RAM's write port. Page DEPTH-1 is reserved as the all-zero page and is never targeted.

## Interface
- QUAN_SIZE, 4, bits per quantised LLR
- CH_IN_NUM, 45, LLRs per input beat
- BEAT_NUM, 17, beats per page (765 LLRs)
- DEPTH, 256, RAM pages including the reserved zero page
- ADDR_WIDTH, $clog2(DEPTH), page address width
- BEAT_WIDTH, CH_IN_NUM*QUAN_SIZE, bits per beat (180)
- DATA_IN_WIDTH, BEAT_NUM*BEAT_WIDTH, page width (3060)

Ports (one clock; reset is asynchronous and active-low):
- write_clk  input  1  sole clock; all state updates on rising edge
- rstn  input  1  asynchronous active-low reset
- load_start_i  input  1  one-cycle start pulse; sampled only in IDLE
- load_base_addr_i  input  ADDR_WIDTH  first page address, sampled with load_start_i
- load_page_num_i  input  ADDR_WIDTH  number of pages to load, sampled with load_start_i
- ch_valid_i  input  1  beat valid
- ch_data_i  input  BEAT_WIDTH  beat payload; LLR j at bits [(j+1)*QUAN_SIZE-1 : j*QUAN_SIZE]
- ch_ready_o  output  1  loader can accept a beat
- we_o  output  1  RAM write enable, one cycle per page
- write_addr_o  output  ADDR_WIDTH  RAM page address
- din_o  output  DATA_IN_WIDTH  packed page
- busy_o  output  1  high in every state except IDLE
- done_o  output  1  one-cycle pulse when the run completes

## Operation
- States: IDLE, FILL, WRITE, DONE.
- IDLE:
  - On load_start_i, latch the base address and page count.
  - If the base address is ≥ DEPTH-1, clamp it to 0.
  - If the page count is 0, go to DONE. Otherwise clear the beat counter and go to FILL.
  - load_start_i outside IDLE is ignored.
- FILL:
  - ch_ready_o=1.
  - A beat is accepted when ch_valid_i & ch_ready_o.
  - Beat k (0..BEAT_NUM-1) is stored at din_o bits [(k+1)*BEAT_WIDTH-1 : k*BEAT_WIDTH].
  - The beat counter increments per accepted beat. Accepting beat BEAT_NUM-1 goes to WRITE.
  - Cycles with ch_valid_i=0 do not advance state.
- WRITE (one cycle):
  - we_o=1, ch_ready_o=0. din_o holds the complete page and write_addr_o holds the current page address.
  - Next address = current+1. If current == DEPTH-2, the next address wraps to 0, so page DEPTH-1 is never written.
  - Pages remaining decrements. If it reaches 0, go to DONE; else clear the beat counter and go to FILL.
- DONE (one cycle): done_o=1, then go to IDLE.
- din_o is not cleared between pages; each beat slot is overwritten as the page fills.
- In FILL, din_o and write_addr_o contents are don't-care to the RAM because we_o=0.

## Timing
- Reset (async assert, sync release): state=IDLE, ch_ready_o=0, we_o=0, done_o=0, busy_o=0, write_addr_o=0, din_o=0, counters=0.
- Reset asserted mid-run aborts immediately. The partial page is discarded and no write is issued.
- All outputs are registered or decoded from registered state only. There is no combinational path from ch_valid_i to ch_ready_o.
- start at edge t: busy_o=1 and ch_ready_o=1 from cycle t+1.
- With back-to-back valid, BEAT_NUM beats take BEAT_NUM cycles.
  - Last beat accepted at edge t → we_o=1 in cycle t+1 → ch_ready_o=1 again in cycle t+2.
  - Throughput is 1 page per BEAT_NUM+1 cycles.
- Last page written in cycle t → done_o=1 in cycle t+1 → busy_o=0 and IDLE from cycle t+2.
- Zero-page run: start at edge t → done_o=1 in cycle t+1. we_o is never asserted.
- we_o is never high for two consecutive cycles.

## Test plan
- Single page:
  - Stimulus: base=5, pages=1, 17 back-to-back beats with beat k = all LLRs equal k[3:0].
  - Required: exactly one we_o pulse, at the cycle after beat 16, with write_addr_o=5 and din_o slot k equal to the replicated k. done_o follows one cycle later.
- Multi-page with wrap:
  - Stimulus: base=253, pages=3, DEPTH=256.
  - Required: writes to addresses 253, 254, 0, and never to 255. ch_ready_o is low exactly in each we_o cycle.
- Valid gaps:
  - Stimulus: one page with ch_valid_i toggling 1/0.
  - Required: we_o is asserted only after the 17th accepted beat, and din_o matches the beats in acceptance order.
- Zero count and clamp:
  - pages=0 → done_o pulse at t+1 and no we_o.
  - base=255, pages=1 → write at address 0.
- Ignored start: load_start_i pulsed mid-FILL with a different base → the original address sequence is unaffected.
- Reset mid-page: rstn low after 8 beats → all outputs return to reset values immediately, no we_o, and a new start loads a full 17-beat page correctly.

Source files
------------

// File: rtl/ch_msg_ram_loader.sv
// ---------------------------------------------------------------------------
// ch_msg_ram_loader
//
// Write-side front end for the channel message RAM. Collects BEAT_NUM beats
// of CH_IN_NUM quantised LLRs over a valid/ready handshake, packs them into
// one codeword page and issues a single-cycle write into the RAM write port.
// Page DEPTH-1 is the reserved all-zero page and is never targeted.
//
// Ports:
//   write_clk         sole clock, rising edge
//   rstn              asynchronous active-low reset
//   load_start_i      start pulse, sampled only in IDLE
//   load_base_addr_i  first page address (sampled with start)
//   load_page_num_i   number of pages to load (sampled with start)
//   ch_valid_i        beat valid
//   ch_data_i         beat payload, LLR j at [(j+1)*QUAN_SIZE-1 : j*QUAN_SIZE]
//   ch_ready_o        loader can accept a beat (high throughout FILL)
//   we_o              RAM write enable, one cycle per page
//   write_addr_o      RAM page address
//   din_o             packed page, beat k at [(k+1)*BEAT_WIDTH-1 : k*BEAT_WIDTH]
//   busy_o            high in every state except IDLE
//   done_o            one-cycle pulse at the end of a run
// ---------------------------------------------------------------------------
module ch_msg_ram_loader #(
  parameter int QUAN_SIZE     = 4,
  parameter int CH_IN_NUM     = 45,
  parameter int BEAT_NUM      = 17,
  parameter int DEPTH         = 256,
  parameter int ADDR_WIDTH    = $clog2(DEPTH),
  parameter int BEAT_WIDTH    = CH_IN_NUM * QUAN_SIZE,
  parameter int DATA_IN_WIDTH = BEAT_NUM * BEAT_WIDTH
) (
  input  logic                     write_clk,
  input  logic                     rstn,
  input  logic                     load_start_i,
  input  logic [ADDR_WIDTH-1:0]    load_base_addr_i,
  input  logic [ADDR_WIDTH-1:0]    load_page_num_i,
  input  logic                     ch_valid_i,
  input  logic [BEAT_WIDTH-1:0]    ch_data_i,
  output logic                     ch_ready_o,
  output logic                     we_o,
  output logic [ADDR_WIDTH-1:0]    write_addr_o,
  output logic [DATA_IN_WIDTH-1:0] din_o,
  output logic                     busy_o,
  output logic                     done_o
);

  localparam int BCW = (BEAT_NUM > 1) ? $clog2(BEAT_NUM) : 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FILL  = 2'd1,
    S_WRITE = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t                   state_r;
  logic [BCW-1:0]           beat_cnt_r;
  logic [ADDR_WIDTH-1:0]    addr_r;
  logic [ADDR_WIDTH-1:0]    pages_left_r;
  logic [DATA_IN_WIDTH-1:0] din_r;
  logic [ADDR_WIDTH-1:0]    next_addr_s;
  logic [ADDR_WIDTH-1:0]    start_addr_s;

  // Next page address: step past DEPTH-2 straight to 0 so the reserved page is skipped.
  always_comb begin
    next_addr_s  = addr_r + ADDR_WIDTH'(1);
    start_addr_s = load_base_addr_i;
    if (addr_r == ADDR_WIDTH'(DEPTH - 2)) begin
      next_addr_s = '0;
    end else begin
      next_addr_s = addr_r + ADDR_WIDTH'(1);
    end
    // A base pointing at (or beyond) the reserved page restarts at page 0.
    if (load_base_addr_i >= ADDR_WIDTH'(DEPTH - 1)) begin
      start_addr_s = '0;
    end else begin
      start_addr_s = load_base_addr_i;
    end
  end

  // Load sequencer: page packing, address stepping and run bookkeeping.
  always_ff @(posedge write_clk or negedge rstn) begin
    if (!rstn) begin
      state_r      <= S_IDLE;
      beat_cnt_r   <= '0;
      addr_r       <= '0;
      pages_left_r <= '0;
      din_r        <= '0;
    end else begin
      case (state_r)
        S_IDLE: begin
          if (load_start_i) begin
            addr_r       <= start_addr_s;
            pages_left_r <= load_page_num_i;
            beat_cnt_r   <= '0;
            if (load_page_num_i == '0) begin
              state_r <= S_DONE;
            end else begin
              state_r <= S_FILL;
            end
          end
        end
        S_FILL: begin
          // ch_ready_o is 1 for the whole of FILL, so valid alone accepts a beat.
          if (ch_valid_i) begin
            for (int k = 0; k < BEAT_NUM; k++) begin
              if (beat_cnt_r == BCW'(k)) begin
                din_r[k*BEAT_WIDTH +: BEAT_WIDTH] <= ch_data_i;
              end
            end
            if (beat_cnt_r == BCW'(BEAT_NUM - 1)) begin
              beat_cnt_r <= '0;
              state_r    <= S_WRITE;
            end else begin
              beat_cnt_r <= beat_cnt_r + BCW'(1);
            end
          end
        end
        S_WRITE: begin
          // write_addr_o still shows the current page this cycle; step afterwards.
          addr_r       <= next_addr_s;
          pages_left_r <= pages_left_r - ADDR_WIDTH'(1);
          beat_cnt_r   <= '0;
          if (pages_left_r == ADDR_WIDTH'(1)) begin
            state_r <= S_DONE;
          end else begin
            state_r <= S_FILL;
          end
        end
        S_DONE: begin
          state_r <= S_IDLE;
        end
        default: begin
          state_r <= S_IDLE;
        end
      endcase
    end
  end

  // Outputs decode the registered state only; no path from ch_valid_i to ch_ready_o.
  always_comb begin
    ch_ready_o   = (state_r == S_FILL);
    we_o         = (state_r == S_WRITE);
    done_o       = (state_r == S_DONE);
    busy_o       = (state_r != S_IDLE);
    write_addr_o = addr_r;
    din_o        = din_r;
  end

endmodule
